// File: rtl/mips150_mem_defs.sv
// Shared definitions for the data-memory port: default address width, arbiter states, masks.
package mips150_mem_defs;
  localparam int ADDR_W_DFLT = 12;

  typedef enum logic {
    IDLE     = 1'b0,
    EXT_DONE = 1'b1
  } arbState_t;

  localparam logic [3:0] WMASK_NONE = 4'b0000;
endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles the external master lost to the CPU.
module starve_counter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // With MAX_WAIT = 0 this is constantly true, so the external master always wins.
  assign at_max = (cnt == MAX_VAL);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares data RAM port A between the CPU X stage (priority) and an external req/ack master.
// The external master is forced in after MAX_WAIT lost conflicts by stalling the CPU for one cycle.
module dmem_port_arbiter
  import mips150_mem_defs::*;
#(
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wmask,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  input  logic              ext_req,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [3:0]        ext_wmask,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic [31:0]       ext_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);
  arbState_t   state, stateNext;
  logic        grantExt;
  logic        cntInc;
  logic        atMax;
  logic [31:0] extHold;

  starve_counter #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (cntInc),
    .clr   (grantExt),
    .at_max(atMax)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      extHold <= '0;
    end else begin
      state <= stateNext;
      if (state == EXT_DONE) begin
        extHold <= ram_dout;
      end
    end
  end

  always_comb begin
    stateNext = state;
    grantExt  = 1'b0;
    cntInc    = 1'b0;
    ext_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (ext_req && (!cpu_valid || atMax)) begin
          grantExt  = 1'b1;
          stateNext = EXT_DONE;
        end else begin
          cntInc = ext_req && cpu_valid;
        end
      end
      EXT_DONE: begin
        // CPU owns the port here; any still-held ext_req is not looked at.
        ext_ack   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Port mux; enables are gated while reset is held so nothing is written.
  always_comb begin
    ram_addr  = grantExt ? ext_addr  : cpu_addr;
    ram_din   = grantExt ? ext_wdata : cpu_wdata;
    ram_en    = 1'b0;
    ram_wea   = WMASK_NONE;
    cpu_stall = 1'b0;
    if (!rst) begin
      ram_en    = grantExt || cpu_valid;
      cpu_stall = grantExt && cpu_valid;
      if (grantExt) begin
        ram_wea = ext_wmask;
      end else if (cpu_valid) begin
        ram_wea = cpu_wmask;
      end
    end
  end

  assign cpu_rdata = ram_dout;
  assign ext_rdata = ext_ack ? ram_dout : extHold;
endmodule
